// File: rtl/letc_core_pkg.sv
// Shared LETC core types: memory access sizes, DTCM store-buffer entries and
// the size/alignment to byte-enable decoder used by the data-side responder.
package letc_core_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  // idx holds the full 30-bit word offset; in-range entries have zero upper bits.
  typedef struct packed {
    logic [29:0] idx;
    logic [31:0] data;
    logic [3:0]  be;
  } dtcm_stb_entry_s;

  typedef struct packed {
    logic [3:0] be;
    logic       misaligned;
  } be_result_s;

  function automatic be_result_s size_addr_to_be(input logic [1:0] size,
                                                 input logic [1:0] addr_lo);
    be_result_s r;
    r.be         = 4'b0000;
    r.misaligned = 1'b0;
    case (size)
      MEM_BYTE: r.be = 4'b0001 << addr_lo;
      MEM_HALF: begin
        r.be         = 4'b0011 << addr_lo;
        r.misaligned = addr_lo[0];
      end
      MEM_WORD: begin
        r.be         = 4'b1111;
        r.misaligned = (addr_lo != 2'b00);
      end
      default:  r.misaligned = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/letc_core_dmss_dtcm_if.sv
// DMSS data-side bus: load request/response from M1/M2 and committed stores.
interface letc_core_dmss_dtcm_if;
  logic        load_req;
  logic [31:0] load_addr;
  logic        load_ready;
  logic        load_stall;
  logic        load_flush;
  logic        load_data_valid;
  logic [31:0] load_data;
  logic        load_fault;
  logic        store_valid;
  logic [31:0] store_addr;
  logic [31:0] store_data;
  logic [1:0]  store_size;
  logic        store_ready;
  logic        store_fault;

  modport master (
    output load_req, load_addr, load_stall, load_flush,
           store_valid, store_addr, store_data, store_size,
    input  load_ready, load_data_valid, load_data, load_fault,
           store_ready, store_fault
  );

  modport slave (
    input  load_req, load_addr, load_stall, load_flush,
           store_valid, store_addr, store_data, store_size,
    output load_ready, load_data_valid, load_data, load_fault,
           store_ready, store_fault
  );
endinterface

// File: rtl/letc_core_dtcm_sram.sv
// Single-port byte-enabled data SRAM, one-cycle read latency; stand-in for a
// technology macro. Read data only changes on a read access.
module letc_core_dtcm_sram #(
  parameter int DEPTH_WORDS = 4096
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  input  logic [3:0]                     be,
  output logic [31:0]                    rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // NOTE: storage arrays get no reset; macros cannot clear them and a reset
  // loop would turn the array into flops.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem_q[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/letc_core_dmss_dtcm.sv
// DMSS data-side responder: loads get the SRAM port first, committed stores
// wait in a small buffer that drains in idle cycles and forwards into loads.
module letc_core_dmss_dtcm
  import letc_core_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          STB_DEPTH   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  letc_core_dmss_dtcm_if.slave dmss
);

  localparam int              IDX_W = $clog2(DEPTH_WORDS);
  localparam int              PTR_W = (STB_DEPTH > 1) ? $clog2(STB_DEPTH) : 1;
  localparam int              CNT_W = $clog2(STB_DEPTH + 1);
  localparam logic [31:0]     SPAN  = 32'(DEPTH_WORDS * 4);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(STB_DEPTH);

  dtcm_stb_entry_s  stb_q [STB_DEPTH];
  dtcm_stb_entry_s  stb_d [STB_DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rsp_valid_q, rsp_valid_d, rsp_fault_q, rsp_fault_d;
  logic [31:0]      fwd_data_q, fwd_data_d;
  logic [3:0]       fwd_mask_q, fwd_mask_d;
  logic             store_fault_q, store_fault_d;

  logic [31:0]      ld_off, st_off, sram_rdata;
  logic [29:0]      ld_idx;
  logic             ld_in_range, st_legal, stb_full;
  logic             load_acc, store_acc, enq, drain;
  be_result_s       st_be;
  dtcm_stb_entry_s  new_entry, head_entry;
  logic [35:0]      ld_fwd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(STB_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Overlays an entry's enabled bytes onto an accumulated {mask, data}.
  function automatic logic [35:0] apply_entry(input logic [35:0] acc,
                                              input dtcm_stb_entry_s e);
    logic [35:0] r;
    r = acc;
    for (int b = 0; b < 4; b++) begin
      if (e.be[b]) begin
        r[b*8 +: 8] = e.data[b*8 +: 8];
        r[32 + b]   = 1'b1;
      end
    end
    return r;
  endfunction

  assign ld_off      = dmss.load_addr - BASE_ADDR;
  assign ld_in_range = ld_off < SPAN;
  assign ld_idx      = ld_off[31:2];

  assign st_off   = dmss.store_addr - BASE_ADDR;
  assign st_be    = size_addr_to_be(dmss.store_size, dmss.store_addr[1:0]);
  assign st_legal = (st_off < SPAN) && !st_be.misaligned;
  assign new_entry = '{idx:  st_off[31:2],
                       data: dmss.store_data << {dmss.store_addr[1:0], 3'b000},
                       be:   st_be.be};

  assign stb_full         = (count_q == FULL);
  assign dmss.store_ready = !stb_full;
  assign dmss.load_ready  = !stb_full && !(rsp_valid_q && dmss.load_stall);
  assign load_acc         = dmss.load_req && dmss.load_ready;
  assign store_acc        = dmss.store_valid && dmss.store_ready;
  assign enq              = store_acc && st_legal;
  assign drain            = !load_acc && (count_q != '0);
  assign head_entry       = stb_q[head_q];

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    stb_d   = stb_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq) begin
      stb_d[tail_q] = new_entry;
      tail_d        = ptr_inc(tail_q);
    end
    if (drain) head_d = ptr_inc(head_q);
    case ({enq, drain})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Oldest to youngest so younger entries win; a same-cycle store wins over all.
  always_comb begin
    int               s;
    logic [PTR_W-1:0] slot;
    ld_fwd = '0;
    s      = 0;
    slot   = '0;
    for (int i = 0; i < STB_DEPTH; i++) begin
      s = int'(head_q) + i;
      if (s >= STB_DEPTH) s = s - STB_DEPTH;
      slot = PTR_W'(s);
      if (i < int'(count_q) && stb_q[slot].idx == ld_idx) begin
        ld_fwd = apply_entry(ld_fwd, stb_q[slot]);
      end
    end
    if (enq && new_entry.idx == ld_idx) ld_fwd = apply_entry(ld_fwd, new_entry);
  end

  always_comb begin
    rsp_valid_d   = rsp_valid_q;
    rsp_fault_d   = rsp_fault_q;
    fwd_data_d    = fwd_data_q;
    fwd_mask_d    = fwd_mask_q;
    store_fault_d = store_acc && !st_legal;
    if (dmss.load_flush) rsp_valid_d = 1'b0;
    else if (!(rsp_valid_q && dmss.load_stall)) rsp_valid_d = load_acc;
    if (load_acc) begin
      rsp_fault_d = !ld_in_range;
      fwd_data_d  = ld_fwd[31:0];
      fwd_mask_d  = ld_fwd[35:32];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_fault_q   <= 1'b0;
      fwd_data_q    <= '0;
      fwd_mask_q    <= '0;
      store_fault_q <= 1'b0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_fault_q   <= rsp_fault_d;
      fwd_data_q    <= fwd_data_d;
      fwd_mask_q    <= fwd_mask_d;
      store_fault_q <= store_fault_d;
    end
  end

  always_ff @(posedge clk) begin
    stb_q <= stb_d;
  end

  // Reset must not let a buffered entry reach the array.
  letc_core_dtcm_sram #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
    .clk   (clk),
    .en    (rst_n && (load_acc || drain)),
    .we    (drain),
    .addr  (load_acc ? ld_idx[IDX_W-1:0] : head_entry.idx[IDX_W-1:0]),
    .wdata (head_entry.data),
    .be    (head_entry.be),
    .rdata (sram_rdata)
  );

  always_comb begin
    dmss.load_data = '0;
    if (rsp_valid_q && !rsp_fault_q) begin
      for (int b = 0; b < 4; b++) begin
        dmss.load_data[b*8 +: 8] = fwd_mask_q[b] ? fwd_data_q[b*8 +: 8]
                                                 : sram_rdata[b*8 +: 8];
      end
    end
  end

  assign dmss.load_data_valid = rsp_valid_q;
  assign dmss.load_fault      = rsp_valid_q && rsp_fault_q;
  assign dmss.store_fault     = store_fault_q;

endmodule

// File: tb/tb_letc_core_dmss_dtcm.sv
// Scoreboard bench for the DTCM responder: a byte-level memory model plus a
// queue of pending stores predicts responses; a monitor compares them.
module tb_letc_core_dmss_dtcm;

  localparam int          DEPTH_WORDS = 4096;
  localparam logic [31:0] BASE_ADDR   = 32'h0000_0000;
  localparam int          STB_DEPTH   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  letc_core_dmss_dtcm_if dmss();

  letc_core_dmss_dtcm #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .BASE_ADDR  (BASE_ADDR),
    .STB_DEPTH  (STB_DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .dmss (dmss)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] data;
  } st_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        fault;
  } rsp_t;

  logic [7:0]  mem_m [DEPTH_WORDS*4];
  st_t         pend [$];
  rsp_t        exp_q [$];
  bit          m_valid, m_fault, exp_sfault, just_reset, armed;
  logic [31:0] m_data;
  bit          last_lacc, last_sacc;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %08h, expected %08h", name, cyc, got, exp);
    end
  endtask

  function automatic bit legal(input st_t s);
    logic [31:0] off;
    off = s.addr - BASE_ADDR;
    if (off >= 32'(DEPTH_WORDS * 4)) return 1'b0;
    case (s.size)
      2'd0:    return 1'b1;
      2'd1:    return !s.addr[0];
      2'd2:    return s.addr[1:0] == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void commit(input st_t s);
    logic [31:0] off;
    off = s.addr - BASE_ADDR;
    for (int b = 0; b < (1 << s.size); b++) mem_m[int'(off) + b] = s.data[b*8 +: 8];
  endfunction

  function automatic logic [31:0] overlay(input st_t s, input logic [31:0] woff,
                                          input logic [31:0] w);
    logic [31:0] r, ba;
    r = w;
    for (int b = 0; b < (1 << s.size); b++) begin
      ba = s.addr - BASE_ADDR + 32'(b);
      if (ba[31:2] == woff[31:2]) r[8*ba[1:0] +: 8] = s.data[b*8 +: 8];
    end
    return r;
  endfunction

  function automatic bit exp_lrdy();
    return (pend.size() != STB_DEPTH) && !(m_valid && dmss.load_stall);
  endfunction

  // One clock: check ready/fault flags mid-cycle, then advance the model at the edge.
  task automatic cycle();
    bit          lacc, sacc, f;
    st_t         cur;
    logic [31:0] w, loff;
    @(negedge clk);
    if (armed) begin
      check("load_ready", 32'(dmss.load_ready), 32'(exp_lrdy()));
      check("store_ready", 32'(dmss.store_ready), 32'(pend.size() != STB_DEPTH));
      check("store_fault", 32'(dmss.store_fault), 32'(exp_sfault));
      if (just_reset) begin
        check("rst_valid", 32'(dmss.load_data_valid), 32'd0);
        check("rst_data", dmss.load_data, 32'd0);
        check("rst_fault", 32'(dmss.load_fault), 32'd0);
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      pend.delete();
      m_valid    = 1'b0;
      exp_sfault = 1'b0;
      just_reset = 1'b1;
      armed      = 1'b1;
      last_lacc  = 1'b0;
      last_sacc  = 1'b0;
    end else begin
      just_reset = 1'b0;
      lacc = dmss.load_req && exp_lrdy();
      sacc = dmss.store_valid && (pend.size() != STB_DEPTH);
      cur.addr = dmss.store_addr;
      cur.size = dmss.store_size;
      cur.data = dmss.store_data;
      exp_sfault = sacc && !legal(cur);
      w = '0;
      f = 1'b0;
      if (lacc) begin
        loff = dmss.load_addr - BASE_ADDR;
        if (loff >= 32'(DEPTH_WORDS * 4)) f = 1'b1;
        else begin
          for (int b = 0; b < 4; b++) w[b*8 +: 8] = mem_m[int'({loff[31:2], 2'b00}) + b];
          foreach (pend[i]) w = overlay(pend[i], loff, w);
          if (sacc && legal(cur)) w = overlay(cur, loff, w);
        end
      end
      if (!lacc && pend.size() != 0) begin
        commit(pend[0]);
        void'(pend.pop_front());
      end
      if (sacc && legal(cur)) pend.push_back(cur);
      if (dmss.load_flush) m_valid = 1'b0;
      else if (m_valid && dmss.load_stall) exp_q.push_back('{cyc + 1, m_data, m_fault});
      else if (lacc) begin
        m_valid = 1'b1;
        m_data  = w;
        m_fault = f;
        exp_q.push_back('{cyc + 1, m_data, m_fault});
      end else m_valid = 1'b0;
      last_lacc = lacc;
      last_sacc = sacc;
    end
    #1;
  endtask

  always @(negedge clk) begin
    rsp_t e;
    if (armed && dmss.load_data_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_rsp @cycle %0d: got valid with data %08h, expected no response",
                 cyc, dmss.load_data);
      end else begin
        e = exp_q.pop_front();
        check("rsp_cycle", 32'(cyc), 32'(e.cyc));
        check("load_data", dmss.load_data, e.data);
        check("load_fault", 32'(dmss.load_fault), 32'(e.fault));
      end
    end
  end

  task automatic idle_inputs();
    dmss.load_req    = 1'b0;
    dmss.load_addr   = '0;
    dmss.load_stall  = 1'b0;
    dmss.load_flush  = 1'b0;
    dmss.store_valid = 1'b0;
    dmss.store_addr  = '0;
    dmss.store_data  = '0;
    dmss.store_size  = '0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    dmss.store_valid = 1'b1;
    dmss.store_addr  = a;
    dmss.store_size  = sz;
    dmss.store_data  = d;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    int k;
    set_store(a, sz, d);
    k = 0;
    do begin
      cycle();
      k++;
    end while (!last_sacc && k < 20);
    if (!last_sacc) begin
      n_vec++;
      n_fail++;
      $display("FAIL store_accept_timeout: store to %08h not accepted in 20 cycles", a);
    end
    dmss.store_valid = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a);
    dmss.load_req  = 1'b1;
    dmss.load_addr = a;
    cycle();
    dmss.load_req  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nst;
    idle_inputs();
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
    run(1);

    // Give every word the later loads touch a known value.
    for (int i = 0; i < 20; i++) do_store(32'(i * 4), 2'd2, $urandom);
    run(4);

    // Word store, then read it back after it has drained.
    do_store(32'h10, 2'd2, 32'hDEADBEEF);
    run(2);
    do_load(32'h10);
    run(2);

    // Byte store forwarded into an immediately following load.
    do_store(32'h20, 2'd2, 32'h11223344);
    run(3);
    do_store(32'h21, 2'd0, 32'h000000AA);
    do_load(32'h20);
    run(3);

    // Two stores against back-to-back loads fill the buffer.
    nst = 0;
    for (int k = 0; k < 8; k++) begin
      dmss.load_req  = 1'b1;
      dmss.load_addr = 32'((k % 20) * 4);
      if (nst < 2) set_store(32'h30 + 32'(nst * 4), 2'd2, $urandom);
      else dmss.store_valid = 1'b0;
      cycle();
      if (last_sacc) nst++;
    end
    idle_inputs();
    run(3);
    do_load(32'h30);
    do_load(32'h34);
    run(2);

    // Held response under stall while a pending store drains.
    set_store(32'h44, 2'd2, $urandom);
    dmss.load_req  = 1'b1;
    dmss.load_addr = 32'h40;
    cycle();
    dmss.store_valid = 1'b0;
    dmss.load_addr   = 32'h44;
    dmss.load_stall  = 1'b1;
    run(3);
    dmss.load_stall  = 1'b0;
    cycle();
    idle_inputs();
    run(2);

    // Illegal stores and out-of-range load.
    do_store(32'h03, 2'd1, 32'h0000BEEF);
    do_store(32'h4000, 2'd2, 32'h12345678);
    do_store(32'h08, 2'd3, 32'h12345678);
    run(2);
    do_load(32'h0000_4000);
    do_load(32'h00);
    run(2);

    // Flush on the accept cycle, and flush over a stalled response.
    dmss.load_flush = 1'b1;
    do_load(32'h10);
    dmss.load_flush = 1'b0;
    do_load(32'h18);
    dmss.load_stall = 1'b1;
    dmss.load_flush = 1'b1;
    cycle();
    idle_inputs();
    run(2);

    // Reset with two entries buffered discards them.
    dmss.load_req  = 1'b1;
    dmss.load_addr = 32'h00;
    set_store(32'h08, 2'd2, 32'hCAFEF00D);
    cycle();
    set_store(32'h0C, 2'd2, 32'h0BADBEEF);
    cycle();
    idle_inputs();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    run(1);
    do_load(32'h08);
    do_load(32'h0C);
    run(2);

    // Randomised traffic.
    for (int k = 0; k < 600; k++) begin
      dmss.load_req   = $urandom_range(0, 99) < 60;
      dmss.load_addr  = ($urandom_range(0, 15) == 0) ? 32'h4000 + 32'($urandom_range(0, 19) * 4)
                                                     : 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      dmss.load_stall = $urandom_range(0, 99) < 25;
      dmss.load_flush = $urandom_range(0, 99) < 5;
      dmss.store_valid = $urandom_range(0, 99) < 50;
      dmss.store_size  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      dmss.store_addr  = ($urandom_range(0, 15) == 0) ? 32'h8000_0000 + 32'($urandom_range(0, 79))
                                                      : 32'($urandom_range(0, 79));
      dmss.store_data  = $urandom;
      cycle();
    end
    idle_inputs();
    run(6);
    for (int i = 0; i < 20; i++) do_load(32'(i * 4));
    run(4);

    check("rsp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
